alu_serial: RTL and testbench
=============================

Name: alu_serial

Overview:
- Multi-cycle, digit-serial ALU that sits directly downstream of the ALU control stage.
- Consumes the 4-bit ALU control code (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, illegal 1111) plus two operands.
- Processes DIGIT bits per cycle, LSB first, through a registered carry chain.
- Reports result, zero and overflow flags with a start/busy/done handshake; used by the multi-cycle CPU datapath in place of the combinational ALU.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; N = WIDTH/DIGIT processing cycles (8 at defaults).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled on rising edge when accepting.
- ALUCtrl_i  input  4  operation code from ALU control.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  result_o == 0.
- overflow_o  output  1  signed overflow of ADD/SUB.
- illegal_o  output  1  last op had an unsupported code.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_i low, any time, asynchronous): state IDLE; all outputs 0; internal operand, carry and digit-count registers cleared. An operation in flight is aborted and produces no done_o.
- States: IDLE, BUSY, DONE.
- Accept: in IDLE or DONE, start_i high at edge E0 does the following:
  - Latch src1_i, src2_i and ALUCtrl_i.
  - Clear the digit counter.
  - Set carry = 1 for SUB/SLT, else 0.
  - Go to BUSY; busy_o = 1 from E0.
- start_i while BUSY is ignored; operands and code are not re-sampled.
- Illegal code (any value other than 0000/0001/0010/0110/0111), at E0:
  - Skip BUSY; go to DONE at E0.
  - At E0: result_o = 0, zero_o = 1, overflow_o = 0, illegal_o = 1.
  - done_o = 1 in the cycle after E0; busy_o stays 0.
- BUSY: each edge processes digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT) and increments k.
  - AND/OR: bitwise on the digit.
  - ADD: A + B + carry.
  - SUB/SLT: A + ~B + carry.
  - Carry-out of each digit is registered for the next digit.
- On the edge processing digit N-1 (edge E0+N):
  - result_o takes the full result.
  - zero_o = (result == 0).
  - overflow_o = carry into MSB XOR carry out of MSB for ADD/SUB; 0 for AND/OR/SLT.
  - illegal_o = 0.
  - State goes to DONE; busy_o = 0.
- SLT: result_o = {WIDTH-1 zeros, sign XOR overflow} of the subtraction; zero_o is evaluated on that final value.
- DONE: done_o = 1 for exactly one cycle, then IDLE unless start_i is accepted in that cycle. Back-to-back ops therefore give done_o every N+1 cycles.
- result_o, zero_o, overflow_o and illegal_o hold until the next completion or reset; they do not change during BUSY.
- Latency: N edges from accept to result; done_o visible in the cycle after edge E0+N.
- Wrap-around: ADD/SUB results are modulo 2^WIDTH; final carry-out is discarded except for overflow.

Test Plan:
- ADD 0x00000005 + 0x00000007, start for 1 cycle -> busy_o for 8 cycles; then result_o = 0x0000000C, zero_o = 0, overflow_o = 0, done_o pulses once.
- SUB 0x80000000 - 0x00000001 -> result_o = 0x7FFFFFFF, overflow_o = 1. SUB 0x12345678 - 0x12345678 -> result_o = 0, zero_o = 1.
- SLT 0xFFFFFFFF vs 0x00000001 -> result_o = 1. SLT 0x7FFFFFFF vs 0x80000000 -> result_o = 0, zero_o = 1, overflow_o = 0.
- ALUCtrl_i = 1111 -> done_o one cycle after accept, busy_o never high, result_o = 0, illegal_o = 1. A following legal AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000, illegal_o = 0.
- Hold start_i high with changing operands for 10 cycles starting with OR 0x1 | 0x2 -> first result 0x3; second op accepted in the DONE cycle; operand changes during BUSY have no effect.
- Pull rst_i low for 1 cycle at digit 4 of an ADD -> all outputs 0 immediately, no done_o. A subsequent ADD 1 + 1 -> result_o = 2 after 8 cycles.

Source files
------------

// File: rtl/alu_serial_if.sv
// Request/response bundle between the multi-cycle datapath and the digit-serial ALU.
interface alu_serial_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;
  logic             illegal_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, ALUCtrl_i, src1_i, src2_i,
    input  result_o, zero_o, overflow_o, illegal_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, src1_i, src2_i,
    output result_o, zero_o, overflow_o, illegal_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_serial.sv
// Digit-serial ALU: processes DIGIT bits per cycle LSB first through a registered
// carry, with a start/busy/done handshake and held result/flag registers.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_serial_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  function automatic logic is_legal(input logic [3:0] code);
    return (code == OP_AND) || (code == OP_OR) || (code == OP_ADD) ||
           (code == OP_SUB) || (code == OP_SLT);
  endfunction

  function automatic logic is_sub(input logic [3:0] code);
    return (code == OP_SUB) || (code == OP_SLT);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [3:0]       op_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] result_q;
  logic             zero_q, ovf_q, illegal_q;

  logic             accept, last_digit;
  logic [DIGIT-1:0] a_d, b_d, b_eff, digit_res;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] acc_next, final_res;
  logic             ovf_raw, final_ovf;

  assign accept     = bus.start_i && (state_q != S_BUSY);
  assign last_digit = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BUSY:  if (last_digit) state_d = S_DONE;
      default: begin
        state_d = S_IDLE;
        if (accept) state_d = is_legal(bus.ALUCtrl_i) ? S_BUSY : S_DONE;
      end
    endcase
  end

  always_comb begin
    bus.busy_o = (state_q == S_BUSY);
    bus.done_o = (state_q == S_DONE);
  end

  // One digit slice of the adder/logic unit; the low digit of the shifting operands.
  always_comb begin
    a_d   = a_q[DIGIT-1:0];
    b_d   = b_q[DIGIT-1:0];
    b_eff = is_sub(op_q) ? ~b_d : b_d;
    sum   = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};
    case (op_q)
      OP_AND:  digit_res = a_d & b_d;
      OP_OR:   digit_res = a_d | b_d;
      default: digit_res = sum[DIGIT-1:0];
    endcase
    acc_next = (acc_q >> DIGIT) | (WIDTH'(digit_res) << (WIDTH - DIGIT));
    // Same-sign operands producing an opposite-sign sum equals carry-in XOR carry-out of the MSB.
    ovf_raw   = (a_d[DIGIT-1] == b_eff[DIGIT-1]) && (sum[DIGIT-1] != a_d[DIGIT-1]);
    final_res = acc_next;
    if (op_q == OP_SLT) final_res = WIDTH'(acc_next[WIDTH-1] ^ ovf_raw);
    final_ovf = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? ovf_raw : 1'b0;
  end

  // NOTE: operand, carry and counter registers are reset as well, so an aborted op leaves nothing stale.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      op_q      <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.src1_i;
      b_q     <= bus.src2_i;
      acc_q   <= '0;
      op_q    <= bus.ALUCtrl_i;
      carry_q <= is_sub(bus.ALUCtrl_i);
      cnt_q   <= '0;
      if (!is_legal(bus.ALUCtrl_i)) begin
        result_q  <= '0;
        zero_q    <= 1'b1;
        ovf_q     <= 1'b0;
        illegal_q <= 1'b1;
      end
    end else if (state_q == S_BUSY) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      acc_q   <= acc_next;
      carry_q <= sum[DIGIT];
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_digit) begin
        result_q  <= final_res;
        zero_q    <= (final_res == '0);
        ovf_q     <= final_ovf;
        illegal_q <= 1'b0;
      end
    end
  end

  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.overflow_o = ovf_q;
  assign bus.illegal_o  = illegal_q;
endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: vector table through a scoreboard plus
// hand-written sequences for held start and mid-operation reset.
module tb_alu_serial;
  localparam int WIDTH = 32;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  vec_t vecs[15];

  alu_serial_if #(.WIDTH(WIDTH)) bus ();

  alu_serial #(.WIDTH(WIDTH), .DIGIT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every done_o pulse must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (bus.done_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result_o, e.res);
        check("zero", 32'(bus.zero_o), 32'(e.zero));
        check("overflow", 32'(bus.overflow_o), 32'(e.ovf));
        check("illegal", 32'(bus.illegal_o), 32'(e.ill));
      end
    end
  end

  task automatic wait_done(input int exp_cycles, input string tag);
    int cycles = 0;
    int busy_cnt = 0;
    while (!bus.done_o && cycles < 20) begin
      if (bus.busy_o) busy_cnt++;
      cycles++;
      @(negedge clk_i);
    end
    check({tag, "_latency"}, cycles, exp_cycles);
    check({tag, "_busy_cycles"}, busy_cnt, exp_cycles);
    check({tag, "_busy_at_done"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clk_i);
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = v.ctrl;
    bus.src1_i    = v.a;
    bus.src2_i    = v.b;
    sb.push_back('{v.res, v.zero, v.ovf, v.ill});
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    wait_done(v.ill ? 0 : 8, "op");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_at;
    vecs[0]  = '{4'b0010, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'b0111, 32'h0000_0005, 32'h0000_0007, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'b0011, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'b0010, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0};

    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = 4'b0000;
    bus.src1_i    = '0;
    bus.src2_i    = '0;
    repeat (2) @(negedge clk_i);
    check("reset_result", bus.result_o, 32'h0);
    check("reset_flags", {28'd0, bus.zero_o, bus.overflow_o, bus.illegal_o, bus.busy_o}, 32'h0);
    check("reset_done", 32'(bus.done_o), 32'd0);
    rst_i = 1'b1;

    for (int i = 0; i < 15; i++) run_op(vecs[i]);

    // Start held high: first op OR 1|2, busy-period inputs ignored, second op taken in DONE.
    done_at = -1;
    @(negedge clk_i);
    for (int i = 0; i < 10; i++) begin
      bus.start_i = 1'b1;
      if (i == 0) begin
        bus.ALUCtrl_i = 4'b0001; bus.src1_i = 32'h1; bus.src2_i = 32'h2;
        sb.push_back('{32'h3, 1'b0, 1'b0, 1'b0});
      end else if (i == 9) begin
        bus.ALUCtrl_i = 4'b0010; bus.src1_i = 32'h100; bus.src2_i = 32'h23;
        sb.push_back('{32'h123, 1'b0, 1'b0, 1'b0});
      end else begin
        bus.ALUCtrl_i = (i % 2 == 1) ? 4'b1111 : 4'b0010;
        bus.src1_i    = $urandom;
        bus.src2_i    = $urandom;
      end
      @(negedge clk_i);
      if (bus.done_o && done_at < 0) done_at = i;
    end
    check("held_first_done_cycle", done_at, 8);
    bus.start_i = 1'b0;
    wait_done(8, "held_second");

    // Reset in the middle of an ADD: outputs clear at once and no done follows.
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.ALUCtrl_i = 4'b0010;
    bus.src1_i = 32'h1111_1111; bus.src2_i = 32'h2222_2222;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("abort_result", bus.result_o, 32'h0);
    check("abort_flags", {28'd0, bus.zero_o, bus.overflow_o, bus.illegal_o, bus.busy_o}, 32'h0);
    check("abort_done", 32'(bus.done_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (12) @(negedge clk_i);
    check("abort_no_pending", sb.size(), 0);
    run_op('{4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0});

    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
